// File: rtl/wordle_board_renderer.sv
// Purpose : holds the 6x5 Wordle board and renders tiles, borders and 5x7 glyphs as RGB332.
// Latency : 3 dclk cycles from pix_x/pix_y/video_on/syncs to red/green/blue/hsync/vsync.
// Backpr. : none; one pixel in and one pixel out every dclk cycle.
//
// Ports:
//   dclk, clr_n                     pixel clock, synchronous active-low reset
//   pix_x, pix_y, video_on          active-area coordinates from the counter stage
//   hsync_in, vsync_in              raw syncs, re-timed to match the colour pipeline
//   wr_en, wr_row, wr_col,
//   wr_letter, wr_state, clr_board  board write port from the game logic
//   hsync, vsync, red, green, blue  registered VGA outputs
module wordle_board_renderer #(
    parameter int GRID_X0  = 164,
    parameter int GRID_Y0  = 52,
    parameter int TILE     = 56,
    parameter int BORDER   = 2,
    parameter int GLYPH_X0 = 18,
    parameter int GLYPH_Y0 = 14
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [2:0] wr_col,
    input  logic [4:0] wr_letter,
    input  logic [1:0] wr_state,
    input  logic       clr_board,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam logic [5:0] TILE_W  = 6'(TILE);
    localparam logic [5:0] BRD_LO  = 6'(BORDER);
    localparam logic [5:0] BRD_HI  = 6'(TILE - BORDER);
    localparam logic [5:0] GX_LO   = 6'(GLYPH_X0);
    localparam logic [5:0] GX_HI   = 6'(GLYPH_X0 + 19);
    localparam logic [5:0] GY_LO   = 6'(GLYPH_Y0);
    localparam logic [5:0] GY_HI   = 6'(GLYPH_Y0 + 27);

    localparam logic [7:0] C_BLACK  = 8'b000_000_00;
    localparam logic [7:0] C_WHITE  = 8'b111_111_11;
    localparam logic [7:0] C_BORDER = 8'b100_100_10;
    localparam logic [7:0] C_ABSENT = 8'b011_011_01;
    localparam logic [7:0] C_PRESNT = 8'b110_101_00;
    localparam logic [7:0] C_CORRCT = 8'b010_101_01;

    // 5x7 font, row 0 in bits [34:30], MSB of each row is the leftmost column.
    function automatic logic [34:0] font(input logic [4:0] l);
        case (l)
            5'd1:    font = 35'b01110_10001_10001_11111_10001_10001_10001; // A
            5'd2:    font = 35'b11110_10001_10001_11110_10001_10001_11110; // B
            5'd3:    font = 35'b01110_10001_10000_10000_10000_10001_01110; // C
            5'd4:    font = 35'b11110_10001_10001_10001_10001_10001_11110; // D
            5'd5:    font = 35'b11111_10000_10000_11110_10000_10000_11111; // E
            5'd6:    font = 35'b11111_10000_10000_11110_10000_10000_10000; // F
            5'd7:    font = 35'b01110_10001_10000_10111_10001_10001_01111; // G
            5'd8:    font = 35'b10001_10001_10001_11111_10001_10001_10001; // H
            5'd9:    font = 35'b01110_00100_00100_00100_00100_00100_01110; // I
            5'd10:   font = 35'b00111_00010_00010_00010_00010_10010_01100; // J
            5'd11:   font = 35'b10001_10010_10100_11000_10100_10010_10001; // K
            5'd12:   font = 35'b10000_10000_10000_10000_10000_10000_11111; // L
            5'd13:   font = 35'b10001_11011_10101_10101_10001_10001_10001; // M
            5'd14:   font = 35'b10001_10001_11001_10101_10011_10001_10001; // N
            5'd15:   font = 35'b01110_10001_10001_10001_10001_10001_01110; // O
            5'd16:   font = 35'b11110_10001_10001_11110_10000_10000_10000; // P
            5'd17:   font = 35'b01110_10001_10001_10001_10101_10010_01101; // Q
            5'd18:   font = 35'b11110_10001_10001_11110_10100_10010_10001; // R
            5'd19:   font = 35'b01111_10000_10000_01110_00001_00001_11110; // S
            5'd20:   font = 35'b11111_00100_00100_00100_00100_00100_00100; // T
            5'd21:   font = 35'b10001_10001_10001_10001_10001_10001_01110; // U
            5'd22:   font = 35'b10001_10001_10001_10001_10001_01010_00100; // V
            5'd23:   font = 35'b10001_10001_10001_10101_10101_10101_01010; // W
            5'd24:   font = 35'b10001_10001_01010_00100_01010_10001_10001; // X
            5'd25:   font = 35'b10001_10001_01010_00100_00100_00100_00100; // Y
            5'd26:   font = 35'b11111_00001_00010_00100_01000_10000_11111; // Z
            default: font = '0;                                            // blank, 27..31
        endcase
    endfunction

    // Board: {letter[4:0], state[1:0]} at index row*5+col.
    logic [6:0] board_q [0:29];
    logic [6:0] board_d [0:29];

    // Stage 1 registers
    logic       vo1_q,   vo1_d;
    logic       tile1_q, tile1_d;
    logic [2:0] row1_q,  row1_d;
    logic [2:0] col1_q,  col1_d;
    logic [5:0] ox1_q,   ox1_d;
    logic [5:0] oy1_q,   oy1_d;

    // Stage 2 registers
    logic       vo2_q,     vo2_d;
    logic       tile2_q,   tile2_d;
    logic [4:0] letter2_q, letter2_d;
    logic [1:0] state2_q,  state2_d;
    logic       border2_q, border2_d;
    logic       glyph2_q,  glyph2_d;
    logic [2:0] gx2_q,     gx2_d;
    logic [2:0] gy2_q,     gy2_d;

    // Stage 3 register and sync delay lines
    logic [7:0] rgb_q, rgb_d;
    logic [2:0] hs_q,  hs_d;
    logic [2:0] vs_q,  vs_d;

    // Board write / clear
    logic [5:0] wr_idx;
    logic       wr_ok;

    always_comb begin
        wr_idx = 6'(wr_row) * 6'd5 + 6'(wr_col);
        wr_ok  = (wr_row <= 3'd5) && (wr_col <= 3'd4);
        for (int i = 0; i < 30; i++) begin
            board_d[i] = clr_board ? 7'd0 : board_q[i];
        end
        // A simultaneous clear takes precedence over the write.
        if (!clr_board && wr_en && wr_ok) begin
            board_d[wr_idx[4:0]] = {wr_letter, wr_state};
        end
    end

    // Stage 1: grid-relative coordinates
    logic signed [10:0] rx, ry;
    logic               in_grid;

    always_comb begin
        rx      = $signed({1'b0, pix_x}) - $signed(11'(GRID_X0));
        ry      = $signed({1'b0, pix_y}) - $signed(11'(GRID_Y0));
        in_grid = video_on && (rx >= 11'sd0) && (rx <= 11'sd319)
                           && (ry >= 11'sd0) && (ry <= 11'sd383);
        vo1_d   = video_on;
        col1_d  = rx[8:6];
        row1_d  = ry[8:6];
        ox1_d   = rx[5:0];
        oy1_d   = ry[5:0];
        tile1_d = in_grid && (rx[5:0] < TILE_W) && (ry[5:0] < TILE_W);
    end

    // Stage 2: board lookup, border and glyph-cell decode
    logic [5:0] rd_idx;
    logic [6:0] entry;
    logic [5:0] dx, dy;

    always_comb begin
        rd_idx = 6'(row1_q) * 6'd5 + 6'(col1_q);
        // Row/col are meaningless outside the grid; keep the read in range anyway.
        entry  = (rd_idx < 6'd30) ? board_q[rd_idx[4:0]] : 7'd0;
        dx     = ox1_q - GX_LO;
        dy     = oy1_q - GY_LO;

        vo2_d     = vo1_q;
        tile2_d   = tile1_q;
        letter2_d = entry[6:2];
        state2_d  = entry[1:0];
        border2_d = (ox1_q < BRD_LO) || (ox1_q >= BRD_HI)
                 || (oy1_q < BRD_LO) || (oy1_q >= BRD_HI);
        glyph2_d  = (ox1_q >= GX_LO) && (ox1_q <= GX_HI)
                 && (oy1_q >= GY_LO) && (oy1_q <= GY_HI);
        // Each glyph cell is 4x4 pixels.
        gx2_d     = 3'(dx >> 2);
        gy2_d     = 3'(dy >> 2);
    end

    // Stage 3: font lookup and colour priority
    logic [34:0] gbits;
    logic [4:0]  frow;
    logic        lit;

    always_comb begin
        gbits = font(letter2_q);
        case (gy2_q)
            3'd0:    frow = gbits[34:30];
            3'd1:    frow = gbits[29:25];
            3'd2:    frow = gbits[24:20];
            3'd3:    frow = gbits[19:15];
            3'd4:    frow = gbits[14:10];
            3'd5:    frow = gbits[9:5];
            3'd6:    frow = gbits[4:0];
            default: frow = 5'd0;
        endcase
        lit = glyph2_q && (letter2_q != 5'd0) && frow[3'd4 - gx2_q];

        rgb_d = C_BLACK;
        if (!vo2_q) begin
            rgb_d = C_BLACK;
        end else if (!tile2_q) begin
            rgb_d = C_WHITE;
        end else if (lit) begin
            // Dark letter on an empty tile, white letter on a coloured tile.
            rgb_d = (state2_q == 2'd0) ? C_BLACK : C_WHITE;
        end else begin
            case (state2_q)
                2'd0:    rgb_d = border2_q ? C_BORDER : C_WHITE;
                2'd1:    rgb_d = C_ABSENT;
                2'd2:    rgb_d = C_PRESNT;
                default: rgb_d = C_CORRCT;
            endcase
        end

        hs_d = {hs_q[1:0], hsync_in};
        vs_d = {vs_q[1:0], vsync_in};
    end

    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            for (int i = 0; i < 30; i++) begin
                board_q[i] <= 7'd0;
            end
            vo1_q     <= 1'b0;
            tile1_q   <= 1'b0;
            row1_q    <= 3'd0;
            col1_q    <= 3'd0;
            ox1_q     <= 6'd0;
            oy1_q     <= 6'd0;
            vo2_q     <= 1'b0;
            tile2_q   <= 1'b0;
            letter2_q <= 5'd0;
            state2_q  <= 2'd0;
            border2_q <= 1'b0;
            glyph2_q  <= 1'b0;
            gx2_q     <= 3'd0;
            gy2_q     <= 3'd0;
            rgb_q     <= 8'd0;
            hs_q      <= 3'b111;
            vs_q      <= 3'b111;
        end else begin
            for (int i = 0; i < 30; i++) begin
                board_q[i] <= board_d[i];
            end
            vo1_q     <= vo1_d;
            tile1_q   <= tile1_d;
            row1_q    <= row1_d;
            col1_q    <= col1_d;
            ox1_q     <= ox1_d;
            oy1_q     <= oy1_d;
            vo2_q     <= vo2_d;
            tile2_q   <= tile2_d;
            letter2_q <= letter2_d;
            state2_q  <= state2_d;
            border2_q <= border2_d;
            glyph2_q  <= glyph2_d;
            gx2_q     <= gx2_d;
            gy2_q     <= gy2_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign red   = rgb_q[7:5];
    assign green = rgb_q[4:2];
    assign blue  = rgb_q[1:0];
    assign hsync = hs_q[2];
    assign vsync = vs_q[2];

endmodule

// File: tb/tb_wordle_board_renderer.sv
// Purpose : directed, table-driven bench for wordle_board_renderer.
// Latency : expects colour and syncs exactly 3 dclk cycles after the inputs.
// Backpr. : none; inputs driven every cycle, outputs sampled 1 time unit after each edge.
module tb_wordle_board_renderer;

    logic       dclk = 1'b0;
    logic       clr_n;
    logic [9:0] pix_x, pix_y;
    logic       video_on, hsync_in, vsync_in;
    logic       wr_en, clr_board;
    logic [2:0] wr_row, wr_col;
    logic [4:0] wr_letter;
    logic [1:0] wr_state;
    logic       hsync, vsync;
    logic [2:0] red, green;
    logic [1:0] blue;

    wordle_board_renderer dut (
        .dclk      (dclk),
        .clr_n     (clr_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_letter (wr_letter),
        .wr_state  (wr_state),
        .clr_board (clr_board),
        .hsync     (hsync),
        .vsync     (vsync),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    always #20 dclk = ~dclk;

    localparam logic [7:0] W  = 8'b111_111_11;
    localparam logic [7:0] BK = 8'b000_000_00;
    localparam logic [7:0] GB = 8'b100_100_10;
    localparam logic [7:0] AB = 8'b011_011_01;
    localparam logic [7:0] PR = 8'b110_101_00;
    localparam logic [7:0] CR = 8'b010_101_01;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [21];

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: rgb got %b required %b", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    // Present one pixel and wait out the 3-cycle pipeline.
    task automatic px(input int x, input int y, input logic vo);
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = vo;
        repeat (3) step();
    endtask

    task automatic wr(input int r, input int c, input int l, input int s, input logic clr);
        wr_en     = 1'b1;
        wr_row    = 3'(r);
        wr_col    = 3'(c);
        wr_letter = 5'(l);
        wr_state  = 2'(s);
        clr_board = clr;
        step();
        wr_en     = 1'b0;
        clr_board = 1'b0;
    endtask

    initial begin
        logic [19:0] hp;
        logic [19:0] vp;

        clr_n = 1'b0; pix_x = '0; pix_y = '0; video_on = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        wr_en = 1'b0; clr_board = 1'b0; wr_row = '0; wr_col = '0;
        wr_letter = '0; wr_state = '0;

        // Power-on reset
        repeat (2) step();
        clr_n = 1'b1;
        chk8("reset_rgb", {red, green, blue}, BK);
        chk1("reset_hsync", hsync, 1'b1);
        chk1("reset_vsync", vsync, 1'b1);
        px(164, 60, 1'b1);
        chk8("empty_tile_border", {red, green, blue}, GB);

        // Mid-frame reset with live syncs and a coloured tile
        wr(0, 0, 1, 3, 1'b0);
        hsync_in = 1'b0; vsync_in = 1'b0;
        px(182, 66, 1'b1);
        chk8("pre_reset_rgb", {red, green, blue}, CR);
        chk1("pre_reset_hsync", hsync, 1'b0);
        clr_n = 1'b0;
        repeat (2) step();
        chk8("midframe_reset_rgb", {red, green, blue}, BK);
        chk1("midframe_reset_hsync", hsync, 1'b1);
        chk1("midframe_reset_vsync", vsync, 1'b1);
        clr_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        px(164, 60, 1'b1);
        chk8("reset_clears_board", {red, green, blue}, GB);

        // Out-of-range writes must not alias onto real tiles
        wr(6, 0, 1, 3, 1'b0);
        wr(0, 5, 1, 3, 1'b0);
        wr(7, 0, 1, 3, 1'b0);
        px(164, 116, 1'b1);
        chk8("oor_tile_1_0", {red, green, blue}, GB);
        px(164, 60, 1'b1);
        chk8("oor_tile_0_0", {red, green, blue}, GB);
        px(356, 60, 1'b1);
        chk8("oor_tile_0_3", {red, green, blue}, GB);

        // Clear beats a simultaneous write, and clears earlier writes
        wr(0, 0, 1, 3, 1'b0);
        wr(2, 2, 1, 3, 1'b1);
        px(292, 180, 1'b1);
        chk8("clr_wins_2_2", {red, green, blue}, GB);
        px(164, 60, 1'b1);
        chk8("clr_clears_0_0", {red, green, blue}, GB);

        // Board for the table
        wr(0, 0, 1, 3, 1'b0);   // A, correct
        wr(5, 4, 26, 2, 1'b0);  // Z, present
        wr(0, 2, 27, 1, 1'b0);  // code 27, absent
        wr(1, 1, 1, 0, 1'b0);   // A, empty state

        vt[0]  = '{10'd190, 10'd66,  1'b1, W};   // lit A on green
        vt[1]  = '{10'd182, 10'd66,  1'b1, CR};  // unlit glyph cell, green fill
        vt[2]  = '{10'd100, 10'd100, 1'b1, W};   // left of grid
        vt[3]  = '{10'd220, 10'd60,  1'b1, W};   // gap between tiles
        vt[4]  = '{10'd228, 10'd60,  1'b1, GB};  // empty tile border
        vt[5]  = '{10'd250, 10'd90,  1'b1, W};   // empty tile fill
        vt[6]  = '{10'd312, 10'd66,  1'b1, AB};  // code 27 renders blank
        vt[7]  = '{10'd254, 10'd130, 1'b1, BK};  // lit A on empty tile
        vt[8]  = '{10'd229, 10'd130, 1'b1, GB};  // border of lettered empty tile
        vt[9]  = '{10'd438, 10'd386, 1'b1, W};   // Z row 0 col 0
        vt[10] = '{10'd438, 10'd390, 1'b1, PR};  // Z row 1 col 0
        vt[11] = '{10'd454, 10'd390, 1'b1, W};   // Z row 1 col 4
        vt[12] = '{10'd420, 10'd372, 1'b1, PR};  // coloured tile corner, no border
        vt[13] = '{10'd475, 10'd427, 1'b1, PR};  // last pixel of last tile
        vt[14] = '{10'd476, 10'd427, 1'b1, W};   // just past last tile
        vt[15] = '{10'd300, 10'd436, 1'b1, W};   // below grid
        vt[16] = '{10'd190, 10'd66,  1'b0, BK};  // video off
        vt[17] = '{10'd639, 10'd479, 1'b1, W};   // far corner
        vt[18] = '{10'd446, 10'd410, 1'b1, W};   // Z row 6 col 2
        vt[19] = '{10'd446, 10'd398, 1'b1, W};   // Z row 3 col 2
        vt[20] = '{10'd438, 10'd398, 1'b1, PR};  // Z row 3 col 0

        for (int i = 0; i < 21; i++) begin
            px(int'(vt[i].x), int'(vt[i].y), vt[i].vo);
            chk8($sformatf("px[%0d]", i), {red, green, blue}, vt[i].exp);
        end

        // Sync alignment: output at step j equals input driven at step j-3
        hp = 20'b1011_0011_1000_1101_0110;
        vp = 20'b0110_1001_1100_0101_1011;
        for (int j = 0; j < 23; j++) begin
            if (j >= 3) begin
                chk1($sformatf("hsync[%0d]", j), hsync, hp[j-3]);
                chk1($sformatf("vsync[%0d]", j), vsync, vp[j-3]);
            end
            hsync_in = (j < 20) ? hp[j] : 1'b1;
            vsync_in = (j < 20) ? vp[j] : 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wordle_board_renderer.md
Name: wordle_board_renderer

Overview:
- Pixel-generation stage directly upstream of the VGA output pins, alongside the 640x480 sync/counter stage.
- The counter stage provides active-area pixel coordinates and raw syncs. This block holds the 6x5 Wordle board state and renders tiles, borders and 5x7 letter glyphs.
- Outputs RGB332 with the syncs delayed by the same amount, so colour and sync stay aligned at the connector.
- Game logic writes letters and tile colours through a simple write port.

Parameters:
- GRID_X0, 164, left edge of grid in active-area pixels.
- GRID_Y0, 52, top edge of grid in active-area pixels.
- TILE, 56, tile side in pixels. The tile pitch is fixed at 64, so the gap is 64-TILE.
- BORDER, 2, border width in pixels of empty tiles.
- GLYPH_X0, 18, glyph x offset inside the tile. The glyph is 5x7 scaled by 4, so it is 20x28 pixels.
- GLYPH_Y0, 14, glyph y offset inside the tile.

Ports:
- dclk  in  1  pixel clock, 25 MHz.
- clr_n  in  1  synchronous active-low reset.
- pix_x  in  10  active-area column, 0..639.
- pix_y  in  10  active-area row, 0..479.
- video_on  in  1  1 when pix_x/pix_y are inside the active area.
- hsync_in  in  1  raw hsync from the counter stage.
- vsync_in  in  1  raw vsync from the counter stage.
- wr_en  in  1  board write strobe.
- wr_row  in  3  tile row, 0..5.
- wr_col  in  3  tile column, 0..4.
- wr_letter  in  5  0 = blank, 1..26 = A..Z.
- wr_state  in  2  0 = empty, 1 = absent, 2 = present, 3 = correct.
- clr_board  in  1  clears all 30 tiles.
- hsync  out  1  hsync_in delayed 3 cycles.
- vsync  out  1  vsync_in delayed 3 cycles.
- red  out  3  registered red.
- green  out  3  registered green.
- blue  out  2  registered blue.

Behaviour:
- Reset (clr_n=0 at a dclk edge):
  - All 30 board entries become letter 0, state 0.
  - All pipeline registers clear; red/green/blue=0.
  - hsync/vsync and their delay registers = 1 (inactive).
- Board storage: 30 entries of {letter[4:0], state[1:0]}, indexed row*5+col.
  - wr_en with row<=5 and col<=4 updates the entry at the dclk edge.
  - Out-of-range row/col writes are ignored.
  - clr_board clears all entries in one cycle. If clr_board and wr_en are both active, clear wins.
  - Writes are visible to pipeline reads from the cycle after the write edge. A same-cycle read returns the old value.
- Pipeline, 3 stages, latency exactly 3 dclk cycles for colour and syncs:
  - S1:
    - rx = pix_x - GRID_X0 and ry = pix_y - GRID_Y0, computed 11-bit signed.
    - in_grid = video_on, rx in 0..319, ry in 0..383.
    - col = rx[8:6], row = ry[8:6], ox = rx[5:0], oy = ry[5:0].
    - in_tile = in_grid & ox<TILE & oy<TILE.
    - Register all S1 results plus video_on.
  - S2:
    - Read the board entry for (row,col).
    - border = ox<BORDER | ox>=TILE-BORDER | oy<BORDER | oy>=TILE-BORDER.
    - in_glyph = ox in GLYPH_X0..GLYPH_X0+19 and oy in GLYPH_Y0..GLYPH_Y0+27.
    - gx = (ox-GLYPH_X0)>>2, range 0..4; gy = (oy-GLYPH_Y0)>>2, range 0..6.
    - Register all S2 results.
  - S3:
    - Internal font ROM: 26 glyphs, 7 rows of 5 bits, MSB = leftmost column.
    - A rows: 01110,10001,10001,11111,10001,10001,10001.
    - lit = in_glyph & letter!=0 & font[letter][gy][4-gx].
    - Register the colour.
- Colour priority (first match wins), as r/g/b:
  1. !video_on: 0/0/0.
  2. !in_tile (background or gap): 111/111/11.
  3. lit: state 0 gives 000/000/00; states 1..3 give 111/111/11.
  4. State 0 with border: 100/100/10.
  5. State 0 otherwise: 111/111/11.
  6. State 1: 011/011/01.
  7. State 2: 110/101/00.
  8. State 3: 010/101/01.
- Empty tiles with state 0 draw border only; fill is white.
- Letter codes 27..31 render as blank, lit=0.
- No back-pressure; one pixel in and one pixel out every cycle.

Test Plan:
- Reset mid-frame: hold clr_n=0 for 2 cycles -> red/green/blue=0 and hsync=vsync=1 on the next edge; all tiles read empty.
- Write row 0, col 0, letter 1, state 3, then pixel (190,66) -> after 3 cycles rgb=111/111/11 (lit A pixel). Pixel (182,66) -> 010/101/01.
- Empty tile border/gap: pixel (164,60) -> 100/100/10; pixel (220,60) -> 111/111/11; pixel (100,100) -> 111/111/11.
- Out-of-range write row=6, col=0 and col=5 -> no entry changes. Simultaneous clr_board+wr_en to (2,2) -> tile (2,2) stays empty.
- Sync alignment: toggle hsync_in/vsync_in with a known pattern -> identical pattern on hsync/vsync exactly 3 cycles later; video_on=0 -> rgb 0/0/0 after 3 cycles.
- Write row 5, col 4, letter 26, state 2 and sweep that tile -> yellow fill 110/101/00, white Z glyph pixels, no border.
